seg7_scan_n: RTL and testbench
==============================

# seg7_scan_n

Parametrised multiplexed 7-segment display driver with an integrated debounced BCD event counter. It supersedes the fixed four-digit scan chain (divider, mod-4 scanner, anode decoder, BCD counter, mux, transcoder) with a single block. The block is generalised in digit count, scan rate and debounce length, and adds up/down counting, wrap indication and leading-zero blanking. It sits between the board button/switch inputs and the anode/segment pins of a common-anode display.

## Interface
- `DIGITS`, default 4: number of BCD digits and anodes; legal range 1..8.
- `SCAN_DIV`, default 50000: clk cycles per digit slot; legal range ≥ 2.
- `DEB_CYCLES`, default 16: consecutive stable cycles required to accept a button level change; legal range ≥ 1.
- `clk` in, 1: single system clock; all logic on its rising edge.
- `rst` in, 1: synchronous, active-low reset.
- `button` in, 1: asynchronous raw pushbutton, active-high; one accepted press is one count event.
- `dir` in, 1: count direction, 1 = up, 0 = down; sampled at the count event.
- `blank_lz` in, 1: 1 = suppress leading zeros.
- `an` out, `DIGITS`: anode enables, active-low, one-hot-low or all-high.
- `seg` out, 7: segments `{g,f,e,d,c,b,a}`, active-low.
- `wrap` out, 1: one-cycle pulse when the counter wraps.

## Operation
- **Input synchroniser:** `button` passes through a 2-FF synchroniser giving `btn_s`.
- **Debouncer:**
  - Holds accepted level `btn_a`, reset 0.
  - A counter counts consecutive cycles with `btn_s != btn_a` and clears on any cycle where they are equal.
  - When the counter reaches `DEB_CYCLES`, `btn_a` takes `btn_s` and the counter clears.
- **Count event:** one-cycle rising edge of `btn_a`. Release never counts.
- **Counter:**
  - `DIGITS` BCD decades, value 0..10^DIGITS−1, reset 0.
  - Up: 9 → 0 with carry to the next decade. All-9s → all-0s and `wrap` pulses.
  - Down: 0 → 9 with borrow. All-0s → all-9s and `wrap` pulses.
  - Decade values are never outside 0..9.
- **Scan:**
  - Prescaler counts 0..`SCAN_DIV`−1 and asserts `tick` at the terminal count.
  - On `tick`, slot index `idx` advances 0 → 1 → … → `DIGITS`−1 → 0.
  - Digit 0 is the least significant digit and is driven on `an[0]`.
- **Output stage:**
  - Registered. On the cycle after `idx` changes, `an` has only bit `idx` low and `seg` carries the encoding of decade `idx`.
  - Encoding 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
- **Leading-zero blanking:**
  - Applies when `blank_lz`=1, `idx`>0, and decades `idx`..`DIGITS`−1 are all 0.
  - Then `an` is all 1s and `seg` = 1111111.
  - Digit 0 is never blanked.
- **Display refresh:** the output registers recompute every cycle from the current counter value and `idx`. A count change shows on the next cycle for the digit being scanned.

## Timing
- **Reset values** (cycle after `rst` low): `an` = all 1s, `seg` = 1111111, `wrap` = 0, counter = 0, `idx` = 0, prescaler = 0, `btn_a` = 0, debounce count = 0. These hold while `rst` is low.
- **Press latency:** a `button` rise held steady changes the counter exactly 2 + `DEB_CYCLES` + 1 cycles after the first sampling edge. `wrap` is asserted in that same cycle.
- **Bounce:** a glitch shorter than `DEB_CYCLES` cycles produces no event. The counter restarts from 0 on every mismatch break.
- **Simultaneous events:** a count event coinciding with `tick` applies both. The output register shows the new count at the new `idx`.
- **Direction changes:** `dir` changes between events take effect at the next event only.
- **Reset mid-operation:** reset mid-scan or mid-debounce discards all state. No count event is produced by a button held high through reset release until it is released and re-pressed.
- **Full cycle:** a full display refresh takes `DIGITS` × `SCAN_DIV` cycles.

## Structure
- **Package `seg7_pkg`:**
  - `bcd_t` (4-bit logic).
  - Segment constants `SEG_0`..`SEG_9`, `SEG_BLANK`.
  - Function `bcd_to_seg(bcd_t)` returning the 7-bit active-low pattern; non-BCD input returns `SEG_BLANK`.
- **Sub-module `btn_debounce`:** parameter `DEB_CYCLES`; ports `clk`, `rst`, `din`, `level`, `rise`. It contains the synchroniser and debouncer.
- **Top level:** counter, prescaler, scanner and output stage, using generate loops over `DIGITS`.

## Test plan
Bench parameters: `SCAN_DIV`=4, `DEB_CYCLES`=3, `DIGITS`=4.
- **Reset:** hold `rst`=0 for 5 cycles → `an`=1111, `seg`=1111111, `wrap`=0. Release → first slot `an`=1110, `seg`=1000000.
- **Clean press:** clean press, `dir`=1, held 10 cycles → counter 0001 at cycle 6 after the rise. Exactly one increment. Digit 0 then shows 1111001.
- **Bounce:** button toggles 1,0,1,0 each cycle, then held 1 → one increment only, occurring 3 stable cycles after the last toggle.
- **Wrap:**
  - Preset to 9999 by 9999 presses (or `dir`=0 from 0000), `dir`=1 press → 0000 and `wrap` high for exactly 1 cycle.
  - `dir`=0 press at 0000 → 9999 and `wrap` pulse.
- **Leading-zero blanking:** count 0042, `blank_lz`=1 → over one refresh, slots 2 and 3 give `an`=1111, `seg`=1111111; slot 1 gives `seg`=0011001; slot 0 gives `seg`=0100100. With `blank_lz`=0, slots 2 and 3 show 1000000.
- **Reset mid-operation:** assert `rst` mid-debounce with the button held → after release no event until the button is released and pressed again.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types, segment patterns and BCD-to-segment conversion for the
// multiplexed 7-segment display driver.
package seg7_pkg;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned SEG_W = 7;

    typedef logic [BCD_W-1:0] bcd_t;

    // Active-low patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    function automatic logic [SEG_W-1:0] bcd_to_seg(input bcd_t bcd);
        logic [SEG_W-1:0] pat;
        case (bcd)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_scan_n_btn_debounce.sv
// Pushbutton front end: 2-FF synchroniser, consecutive-cycle debouncer and
// registered press pulse that stays disarmed until a released level is seen.
module btn_debounce
    import seg7_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);

    logic             sync_1;
    logic             btn_s;
    logic [1:0]       sync_vld;
    logic [DEB_W-1:0] deb_cnt;
    logic             armed;
    logic             accept_c;

    assign accept_c = (btn_s != level) && (deb_cnt == DEB_W'(DEB_CYCLES - 1));

    // A button held through reset must not count: presses are only armed once
    // a genuine synchronised sample and the accepted level are both low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_1   <= 1'b0;
            btn_s    <= 1'b0;
            sync_vld <= 2'b00;
            deb_cnt  <= '0;
            level    <= 1'b0;
            rise     <= 1'b0;
            armed    <= 1'b0;
        end else begin
            sync_1   <= din;
            btn_s    <= sync_1;
            sync_vld <= {sync_vld[0], 1'b1};
            rise     <= 1'b0;
            if (btn_s == level) begin
                deb_cnt <= '0;
            end else if (accept_c) begin
                deb_cnt <= '0;
                level   <= btn_s;
                rise    <= btn_s & armed;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
            if (sync_vld[1] && !btn_s && !level) begin
                armed <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_n.sv
// Multiplexed common-anode 7-segment driver with a debounced up/down BCD
// event counter, wrap pulse and optional leading-zero blanking.
module seg7_scan_n
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              button,
    input  logic              dir,
    input  logic              blank_lz,
    output logic [DIGITS-1:0] an,
    output logic [SEG_W-1:0]  seg,
    output logic              wrap
);

    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned PRE_W = $clog2(SCAN_DIV);

    logic                    rise;
    logic                    btn_level;
    logic                    event_c;
    bcd_t [DIGITS-1:0]       dec_q;
    bcd_t [DIGITS-1:0]       dec_d;
    logic [DIGITS:0]         low_nine_c;
    logic [DIGITS:0]         low_zero_c;
    logic [DIGITS-1:0]       hi_zero_c;
    logic [PRE_W-1:0]        pre_q;
    logic                    tick_c;
    logic [IDX_W-1:0]        idx_q;
    logic [DIGITS-1:0]       an_c;
    logic                    blank_c;
    logic                    run_zero;

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_btn (
        .clk  (clk),
        .rst  (rst),
        .din  (button),
        .level(btn_level),
        .rise (rise)
    );

    // rise is only ever raised together with the accepted level going high
    assign event_c = rise & btn_level;

    // Carry/borrow chains from below and zero-run from the top for blanking
    always_comb begin
        low_nine_c    = '0;
        low_zero_c    = '0;
        hi_zero_c     = '0;
        run_zero      = 1'b1;
        low_nine_c[0] = 1'b1;
        low_zero_c[0] = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            low_nine_c[i+1] = low_nine_c[i] && (dec_q[i] == 4'd9);
            low_zero_c[i+1] = low_zero_c[i] && (dec_q[i] == 4'd0);
        end
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            run_zero     = run_zero && (dec_q[i] == 4'd0);
            hi_zero_c[i] = run_zero;
        end
    end

    always_comb begin
        dec_d = dec_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (event_c && dir && low_nine_c[i]) begin
                dec_d[i] = (dec_q[i] == 4'd9) ? 4'd0 : dec_q[i] + 4'd1;
            end else if (event_c && !dir && low_zero_c[i]) begin
                dec_d[i] = (dec_q[i] == 4'd0) ? 4'd9 : dec_q[i] - 4'd1;
            end
        end
    end

    assign tick_c  = (pre_q == PRE_W'(SCAN_DIV - 1));
    assign blank_c = blank_lz && (idx_q != '0) && hi_zero_c[idx_q];

    for (genvar i = 0; i < DIGITS; i++) begin : g_an
        assign an_c[i] = (idx_q != IDX_W'(i));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dec_q <= '0;
            pre_q <= '0;
            idx_q <= '0;
            an    <= '1;
            seg   <= SEG_BLANK;
            wrap  <= 1'b0;
        end else begin
            dec_q <= dec_d;
            pre_q <= tick_c ? '0 : pre_q + PRE_W'(1);
            if (tick_c) begin
                idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
            end
            wrap <= event_c && (dir ? low_nine_c[DIGITS] : low_zero_c[DIGITS]);
            if (blank_c) begin
                an  <= '1;
                seg <= SEG_BLANK;
            end else begin
                an  <= an_c;
                seg <= bcd_to_seg(dec_q[idx_q]);
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_n.sv
// Directed bench for seg7_scan_n: a decimal-level model is compared with the
// display outputs every cycle, plus literal checks of the key scenarios.
module tb_seg7_scan_n;

    localparam int DIGITS     = 4;
    localparam int SCAN_DIV   = 4;
    localparam int DEB_CYCLES = 3;

    logic              clk;
    logic              rst;
    logic              button;
    logic              dir;
    logic              blank_lz;
    logic [DIGITS-1:0] an;
    logic [6:0]        seg;
    logic              wrap;

    int n_chk  = 0;
    int n_pass = 0;

    seg7_scan_n #(
        .DIGITS    (DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .DEB_CYCLES(DEB_CYCLES)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .button  (button),
        .dir     (dir),
        .blank_lz(blank_lz),
        .an      (an),
        .seg     (seg),
        .wrap    (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Behavioural model: decimal counter value, windowed debounce, time-based scan slot
    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};
    int pow10 [4] = '{1, 10, 100, 1000};

    int         cnt_m;
    bit         lvl, armed, rise_p, model_vld;
    int         n_edges, t_scan;
    bit         bq [$];
    bit         sq [$];
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_wrap;

    initial model_vld = 1'b0;

    always @(posedge clk) begin
        int  didx, hi;
        bit  bs, arm_set, all_diff;
        if (!rst) begin
            cnt_m = 0; lvl = 0; armed = 0; rise_p = 0; n_edges = 0; t_scan = 0;
            bq = '{1'b0, 1'b0};
            sq.delete();
            exp_an = 4'hF; exp_seg = 7'h7F; exp_wrap = 1'b0;
        end else begin
            t_scan++;
            didx = ((t_scan - 1) / SCAN_DIV) % DIGITS;
            hi   = cnt_m / pow10[didx];
            if (blank_lz && didx > 0 && hi == 0) begin
                exp_an = 4'hF; exp_seg = 7'h7F;
            end else begin
                exp_an  = ~(4'b0001 << didx);
                exp_seg = seg_tab[hi % 10];
            end
            exp_wrap = 1'b0;
            if (rise_p) begin
                if (dir) begin
                    if (cnt_m == 9999) begin cnt_m = 0; exp_wrap = 1'b1; end
                    else cnt_m++;
                end else begin
                    if (cnt_m == 0) begin cnt_m = 9999; exp_wrap = 1'b1; end
                    else cnt_m--;
                end
            end
            n_edges++;
            bs = bq.pop_front();
            bq.push_back(button);
            arm_set = (n_edges >= 3) && !bs && !lvl;
            rise_p  = 1'b0;
            sq.push_back(bs);
            if (sq.size() > DEB_CYCLES) void'(sq.pop_front());
            all_diff = (sq.size() == DEB_CYCLES);
            foreach (sq[i]) if (sq[i] == lvl) all_diff = 1'b0;
            if (all_diff) begin
                lvl    = !lvl;
                rise_p = lvl && armed;
                sq.delete();
            end
            if (arm_set) armed = 1'b1;
        end
        model_vld = 1'b1;
    end

    always @(negedge clk) begin
        if (model_vld) begin
            check("an_model",   32'(an),   32'(exp_an));
            check("seg_model",  32'(seg),  32'(exp_seg));
            check("wrap_model", 32'(wrap), 32'(exp_wrap));
        end
    end

    task automatic press(output int wraps);
        wraps  = 0;
        button = 1'b1;
        repeat (10) begin @(negedge clk); if (wrap) wraps++; end
        button = 1'b0;
        repeat (10) begin @(negedge clk); if (wrap) wraps++; end
    endtask

    task automatic slot_seg(input logic [3:0] a, output logic [6:0] s, output bit found);
        found = 1'b0;
        s     = 7'h00;
        repeat (DIGITS * SCAN_DIV) begin
            @(negedge clk);
            if (an == a) begin found = 1'b1; s = seg; end
        end
    endtask

    initial begin
        int         w;
        int         blanks, zeros;
        logic [6:0] s;
        bit         found;

        rst = 1'b0; button = 1'b0; dir = 1'b1; blank_lz = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_an",   32'(an),   32'h0000000F);
        check("reset_seg",  32'(seg),  32'h0000007F);
        check("reset_wrap", 32'(wrap), 32'h00000000);
        rst = 1'b1;
        @(negedge clk);
        check("first_an",  32'(an),  32'b1110);
        check("first_seg", 32'(seg), 32'b1000000);
        repeat (10) @(negedge clk);

        // Clean press: counter moves on the 6th edge after the rise
        button = 1'b1;
        repeat (5) @(negedge clk);
        check("press_lat_before", 32'(dut.dec_q), 32'h0000);
        @(negedge clk);
        check("press_lat_at", 32'(dut.dec_q), 32'h0001);
        repeat (4) @(negedge clk);
        button = 1'b0;
        repeat (10) @(negedge clk);
        check("press_once", 32'(dut.dec_q), 32'h0001);
        check("model_one", 32'(cnt_m), 32'd1);
        slot_seg(4'b1110, s, found);
        check("d0_found", 32'(found), 32'd1);
        check("d0_seg_one", 32'(s), 32'b1111001);

        // Bounce: 1,0,1,0 then held high
        button = 1'b1; @(negedge clk);
        button = 1'b0; @(negedge clk);
        button = 1'b1; @(negedge clk);
        button = 1'b0; @(negedge clk);
        button = 1'b1;
        repeat (5) @(negedge clk);
        check("bounce_before", 32'(dut.dec_q), 32'h0001);
        @(negedge clk);
        check("bounce_at", 32'(dut.dec_q), 32'h0002);
        repeat (6) @(negedge clk);
        button = 1'b0;
        repeat (10) @(negedge clk);
        check("bounce_once", 32'(dut.dec_q), 32'h0002);

        // Down to zero, then wrap both ways
        dir = 1'b0;
        press(w); press(w);
        check("down_zero", 32'(dut.dec_q), 32'h0000);
        press(w);
        check("wrap_dn_pulse", 32'(w), 32'd1);
        check("wrap_dn_val", 32'(dut.dec_q), 32'h9999);
        check("model_9999", 32'(cnt_m), 32'd9999);
        dir = 1'b1;
        press(w);
        check("wrap_up_pulse", 32'(w), 32'd1);
        check("wrap_up_val", 32'(dut.dec_q), 32'h0000);

        // Count to 42 and inspect blanking over full refreshes
        for (int i = 0; i < 42; i++) press(w);
        check("count_42", 32'(dut.dec_q), 32'h0042);
        check("model_42", 32'(cnt_m), 32'd42);
        blank_lz = 1'b1;
        blanks = 0;
        repeat (DIGITS * SCAN_DIV) begin
            @(negedge clk);
            if (an == 4'b1111 && seg == 7'h7F) blanks++;
        end
        check("lz_blank_slots", 32'(blanks), 32'd8);
        slot_seg(4'b1101, s, found);
        check("lz_d1", 32'(s), 32'b0011001);
        slot_seg(4'b1110, s, found);
        check("lz_d0", 32'(s), 32'b0100100);
        blank_lz = 1'b0;
        @(negedge clk);
        zeros = 0;
        repeat (DIGITS * SCAN_DIV) begin
            @(negedge clk);
            if ((an == 4'b1011 || an == 4'b0111) && seg == 7'b1000000) zeros++;
        end
        check("nolz_zero_slots", 32'(zeros), 32'd8);

        // Reset mid-debounce with the button held high
        button = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("held_no_event", 32'(dut.dec_q), 32'h0000);
        check("held_no_wrap_model", 32'(cnt_m), 32'd0);
        button = 1'b0;
        repeat (10) @(negedge clk);
        press(w);
        check("repress_event", 32'(dut.dec_q), 32'h0001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
